module_led_arbiter: RTL
=======================

MODULE_LED_ARBITER -- requirements
Module: module_led_arbiter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the stable-input cycles required before a button level is accepted (5 ms at 100 MHz).
REQ-002 The block SHALL have parameter SLOT_CYCLES, default 100000000, giving the maximum grant duration while other requests are pending (1 s at 100 MHz).
REQ-003 Port clk SHALL be an input, 1 bit wide, and serve as the single system clock; all flops SHALL be on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and act as an asynchronous, active-low reset.
REQ-005 Ports push_button_0 .. push_button_3 SHALL each be an input, 1 bit wide, asynchronous and active-high; they are requesters 0..3.
REQ-006 Ports sw_0_3, sw_4_7, sw_8_11 and sw_12_15 SHALL each be an input, 4 bits wide, carrying the data groups of requesters 0..3.
REQ-007 Port leds_o SHALL be an output, 4 bits wide, driving the shared LED bank.
REQ-008 Port grant_o SHALL be an output, 4 bits wide, one-hot; bit k set means requester k owns leds_o.
REQ-009 Port busy_o SHALL be an output, 1 bit wide, high whenever any grant_o bit is set.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer and then a per-button debounce counter.
REQ-011 The debounced request req[k] SHALL take the synchronized value only after that value has differed from req[k] for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-012 The FSM SHALL have two states, IDLE and GRANT, with the owner index and slot counter registered.
REQ-013 In IDLE, when any req is high, the FSM SHALL enter GRANT on the next edge, with the owner chosen round-robin.
REQ-014 Round-robin selection SHALL search upward from last_owner+1 with wrap 3->0 and take the first asserted req.
REQ-015 In GRANT, if req[owner] drops and another req is high, ownership SHALL pass round-robin on the next edge and the slot counter SHALL clear.
REQ-016 In GRANT, if req[owner] drops and no other req is high, the FSM SHALL return to IDLE on the next edge.
REQ-017 In GRANT, when the slot counter reaches SLOT_CYCLES-1 and another req is high, ownership SHALL rotate round-robin on the next edge and the slot counter SHALL clear.
REQ-018 If the slot counter reaches SLOT_CYCLES-1 with no other req high, the owner SHALL be kept and the slot counter SHALL hold at SLOT_CYCLES-1 (no wrap).
REQ-019 grant_o SHALL be registered.
REQ-020 leds_o SHALL equal the granted requester's switch group, combinationally muxed from registered grant_o and live switches; leds_o SHALL be 4'b0000 when no grant is set.
REQ-021 Latency from a clean press to grant_o SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-022 Simultaneous requests SHALL resolve only through REQ-014; there SHALL be no fixed priority.
REQ-023 last_owner SHALL update on every grant.
REQ-024 grant_o SHALL never have more than one bit set.

Reset
REQ-025 rst_n low SHALL asynchronously force all of the following, including mid-grant: state=IDLE, grant_o=0, busy_o=0, leds_o=0, req=0, synchronizers=0, debounce and slot counters=0, last_owner=3.
REQ-026 After release, the first grant SHALL favor requester 0.

Configuration
REQ-027 With macro LED_ARB_CONFLICT_EN defined, the block SHALL add a 1-bit output conflict_o, registered, high while two or more debounced reqs are high.
REQ-028 Without LED_ARB_CONFLICT_EN, port conflict_o and its logic SHALL be absent and all other behavior SHALL be identical.

Verification (DEBOUNCE_CYCLES=4, SLOT_CYCLES=8)
REQ-029 Scenario 1: reset, press button 0 clean with sw_0_3=4'b1000 -> grant_o=0001 and leds_o=1000 exactly 7 cycles after the press; release -> grant_o=0000 and leds_o=0000.
REQ-030 Scenario 2: toggle button 1 every 2 cycles for 20 cycles, then release -> grant_o stays 0000 throughout.
REQ-031 Scenario 3: hold buttons 0 and 2 together, sw_8_11=4'b1110 -> owner 0 for 8 cycles, then grant_o=0100 with leds_o=1110, alternating every 8 cycles.
REQ-032 Scenario 4: owner 2 releases while buttons 1 and 3 are held -> the next grant is 1000 (search from 3), not 0010.
REQ-033 Scenario 5: assert rst_n=0 mid-grant -> all outputs are 0 in the same cycle, asynchronously; after release, a held button 3 is regranted after debounce.
REQ-034 Scenario 6 (LED_ARB_CONFLICT_EN defined): two buttons held -> conflict_o=1 one cycle after the second req; drop to one button -> conflict_o=0.

Source files
------------

// File: rtl/module_led_arbiter.sv
// module_led_arbiter: debounced round-robin arbiter granting four push-button requesters the LED bank (optional LED_ARB_CONFLICT_EN adds conflict_o)
module module_led_arbiter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SLOT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_button_0,
  input  logic       push_button_1,
  input  logic       push_button_2,
  input  logic       push_button_3,
  input  logic [3:0] sw_0_3,
  input  logic [3:0] sw_4_7,
  input  logic [3:0] sw_8_11,
  input  logic [3:0] sw_12_15,
  output logic [3:0] leds_o,
  output logic [3:0] grant_o,
  output logic       busy_o
`ifdef LED_ARB_CONFLICT_EN
  ,
  output logic       conflict_o
`endif
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SLW = $clog2(SLOT_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SLW-1:0] SLOT_MAX = SLW'(SLOT_CYCLES - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [3:0] btn, sync1, sync2, req, others, grant_nx;
  logic [DW-1:0] db_cnt [4];
  logic [1:0] owner, owner_nx;
  logic [SLW-1:0] slot, slot_nx;
  function automatic logic [1:0] rr_pick(input logic [3:0] m, input logic [1:0] base);
    rr_pick = base;
    for (int i = 4; i >= 1; i--) if (m[2'(base + 2'(i))]) rr_pick = 2'(base + 2'(i));
  endfunction
  assign btn = {push_button_3, push_button_2, push_button_1, push_button_0};
  assign others = req & ~(4'b0001 << owner);
  // synchronize buttons, accept a new level only after DEBOUNCE_CYCLES stable cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      req <= '0;
      for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int k = 0; k < 4; k++) begin
        if (sync2[k] == req[k]) db_cnt[k] <= '0;
        else if (db_cnt[k] == DB_MAX) begin
          req[k] <= sync2[k];
          db_cnt[k] <= '0;
        end else db_cnt[k] <= db_cnt[k] + 1'b1;
      end
    end
  end
  // arbiter state, owner (doubles as last_owner), slot counter and registered grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 2'd3;
      slot <= '0;
      grant_o <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      slot <= slot_nx;
      grant_o <= grant_nx;
    end
  end
  // next state: round-robin hand-off on release or slot expiry, slot holds at its maximum when uncontested
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    slot_nx = slot;
    if (state == IDLE) begin
      if (|req) begin
        state_nx = GRANT;
        owner_nx = rr_pick(req, owner);
        slot_nx = '0;
      end
    end else if (!req[owner] || slot == SLOT_MAX) begin
      if (|others) begin
        owner_nx = rr_pick(others, owner);
        slot_nx = '0;
      end else if (!req[owner]) begin
        state_nx = IDLE;
        slot_nx = '0;
      end
    end else slot_nx = slot + 1'b1;
    grant_nx = (state_nx == GRANT) ? 4'b0001 << owner_nx : 4'b0000;
  end
  // outputs: LED mux from registered grant and live switches
  always_comb begin
    leds_o = grant_o[0] ? sw_0_3 : grant_o[1] ? sw_4_7 : grant_o[2] ? sw_8_11 : grant_o[3] ? sw_12_15 : 4'b0000;
    busy_o = |grant_o;
  end
`ifdef LED_ARB_CONFLICT_EN
  // flag two or more debounced requests at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_o <= 1'b0;
    else conflict_o <= |(req & (req - 4'd1));
  end
`endif
endmodule
